// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-input round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {IDLE, OWNED} state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set mask bit in order ptr+1, ptr+2, ptr+3, ptr.
module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);
    logic [ID_W-1:0] cand;

    // Walk from farthest to nearest so the nearest candidate is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + ID_W'(k);
            if (mask[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_4input.sv
// 4-input round-robin arbiter with registered one-hot grant and zero-bubble handoff.
// Optional per-owner grant timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_4input
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               any_req
);
    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic [ID_W-1:0]    pick_base;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               release_own;
    logic               handoff;

    assign any_req = |req;

    // While owned, search starts after the owner and never re-picks it.
    assign pick_mask   = (state == OWNED) ? (req & ~gnt) : req;
    assign pick_base   = (state == OWNED) ? gnt_id : ptr;
    assign release_own = (state == OWNED) && !req[gnt_id];

    rr_priority_pick u_pick (
        .mask  (pick_mask),
        .ptr   (pick_base),
        .found (pick_found),
        .index (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = 8;
    logic [CNT_W-1:0] cnt;
    logic             expired;

    assign expired = (state == OWNED) && (cnt >= CNT_W'(TIMEOUT_CYCLES)) && pick_found;
    assign handoff = release_own || expired;

    // cnt holds the number of cycles the current grant has been visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE || handoff) begin
            cnt <= pick_found ? CNT_W'(1) : '0;
        end else if (cnt < CNT_W'(TIMEOUT_CYCLES)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign handoff = release_own;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            ptr    <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state  <= OWNED;
                        gnt    <= NUM_REQ'(1) << pick_idx;
                        gnt_id <= pick_idx;
                        busy   <= 1'b1;
                    end
                end
                OWNED: begin
                    if (handoff) begin
                        ptr <= gnt_id;
                        if (pick_found) begin
                            gnt    <= NUM_REQ'(1) << pick_idx;
                            gnt_id <= pick_idx;
                        end else begin
                            state  <= IDLE;
                            gnt    <= '0;
                            gnt_id <= '0;
                            busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    gnt_id <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter_4input.sv
// Randomized and directed bench for rr_arbiter_4input against an ownership-level model.
module tb_rr_arbiter_4input;
    localparam int TO = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       any_req;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index (-1 = idle), last-owner pointer, cycles owned.
    int m_owner;
    int m_ptr;
    int m_cnt;

    rr_arbiter_4input #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .any_req (any_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [3:0] mask, int base, int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (base + k) % 4;
            if (c != excl && mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    function automatic logic [1:0] exp_id();
        return (m_owner < 0) ? 2'd0 : 2'(m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        int  nxt;
        bit  rel;
        bit  to;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            nxt = pick(req, m_ptr, -1);
            if (nxt >= 0) begin
                m_owner = nxt;
                m_cnt   = 1;
            end
        end else begin
            rel = !req[m_owner];
            to  = 1'b0;
            nxt = pick(req, m_owner, m_owner);
`ifdef ARB_TIMEOUT_EN
            to = (m_cnt >= TO) && (nxt >= 0);
`endif
            if (rel || to) begin
                m_ptr   = m_owner;
                m_owner = nxt;
                m_cnt   = (nxt >= 0) ? 1 : 0;
            end else if (m_cnt < TO) begin
                m_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'($urandom);
        model_reset();
        #1;
        n_tests++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b id=%0d busy=%b required 0000/0/0", gnt, gnt_id, busy);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: gnt=%b busy=%b required 0000/0 with rst high", gnt, busy);
        end
        rst = 1'b0;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_any_req();
        for (int r = 0; r < 2; r++) begin
            rst = r[0];
            for (int p = 0; p < 16; p++) begin
                req = 4'(p);
                #1;
                n_tests++;
                if (any_req !== (p != 0)) begin
                    n_fail++;
                    $display("FAIL any_req: req=%b rst=%b got %b required %b", req, rst, any_req, p != 0);
                end
            end
        end
        req = 4'b0000;
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_handoff();
        do_reset();
        req = 4'b1111;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: gnt=%b id=%0d busy=%b required 0001/0/1", gnt, gnt_id, busy);
        end
        req = 4'b1110;
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            n_fail++;
            $display("FAIL zero_bubble: gnt=%b id=%0d required 0010/1", gnt, gnt_id);
        end
    endtask

    task automatic test_idle_return();
        req = 4'b0100;
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL owner2: gnt=%b id=%0d required 0100/2", gnt, gnt_id);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL owner2_hold: gnt=%b required 0100", gnt);
        end
        req = 4'b0000;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL to_idle: gnt=%b busy=%b id=%0d required 0000/0/0", gnt, busy, gnt_id);
        end
        req = 4'b0001;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_regrant: gnt=%b busy=%b required 0001/1", gnt, busy);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            want = 4'(1 << (i % 4));
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (gnt !== want || gnt_id !== 2'(i % 4)) begin
                    n_fail++;
                    $display("FAIL rotation[%0d.%0d]: gnt=%b id=%0d required %b/%0d", i, c, gnt, gnt_id, want, i % 4);
                end
                if (c < 2) tick();
            end
            if (i < 4) begin
                req = 4'b1111 & ~want;
                tick();
                req = 4'b1111;
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        tick();
        n_tests++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL owner3: gnt=%b id=%0d required 1000/3", gnt, gnt_id);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b busy=%b id=%0d required 0000/0/0", gnt, busy, gnt_id);
        end
        #1 rst = 1'b0;
        model_reset();
        tick();
        n_tests++;
        if (gnt !== 4'b1000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_grant: gnt=%b busy=%b required 1000/1", gnt, busy);
        end
        req = 4'b0000;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        tick();
        for (int c = 0; c < TO; c++) begin
            n_tests++;
            if (gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL timeout_hold[%0d]: gnt=%b required 0001", c, gnt);
            end
            if (c < TO - 1) tick();
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL timeout_handoff: gnt=%b required 0010", gnt);
        end
        req = 4'b0001;
        tick();
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if (gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL timeout_saturate[%0d]: gnt=%b required 0001", c, gnt);
            end
            tick();
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    task automatic test_random();
        do_reset();
        req = 4'b0000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                n_tests++;
                if (gnt !== 4'b0000 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_reset[%0d]: gnt=%b busy=%b required 0000/0", cyc, gnt, busy);
                end
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
            n_tests++;
            if (gnt !== exp_gnt() || gnt_id !== exp_id() || busy !== (m_owner >= 0) || any_req !== (|req)) begin
                n_fail++;
                $display("FAIL random[%0d]: req=%b gnt=%b id=%0d busy=%b any=%b required gnt=%b id=%0d busy=%b",
                         cyc, req, gnt, gnt_id, busy, any_req, exp_gnt(), exp_id(), m_owner >= 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        test_reset();
        test_any_req();
        test_handoff();
        test_idle_return();
        test_rotation();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
